square_anim_ctrl: RTL and testbench
===================================

SQUARE_ANIM_CTRL -- requirements
Module: square_anim_ctrl

Interface
REQ-001 SHALL have parameter CORDW, default 10, coordinate width.
REQ-002 SHALL have parameter H_RES, default 640, active pixels per line.
REQ-003 SHALL have parameter V_RES, default 480, active lines per frame.
REQ-004 SHALL have parameter Q_SIZE, default 200, square side in pixels.
REQ-005 SHALL have parameter Q_SPEED, default 2, pixels moved per axis per frame.
REQ-006 SHALL have parameters Q_X0 and Q_Y0, defaults 220 and 140, reset position of the top-left corner.
REQ-007 SHALL have port clk_pix, input, 1, pixel clock; the block uses one clock only.
REQ-008 SHALL have port rst_pix_n, input, 1, reset, asynchronous and active-low.
REQ-009 SHALL have ports sx and sy, input, CORDW each, current screen position from the display timing block.
REQ-010 SHALL have port de, input, 1, data enable.
REQ-011 SHALL have ports pause and step, input, 1 each, level-sensitive freeze and single-frame advance.
REQ-012 SHALL have ports qx and qy, output, CORDW each, square top-left position.
REQ-013 SHALL have ports paint_r, paint_g and paint_b, output, 4 each, pixel colour.
REQ-014 SHALL have ports bounce, output, 1, one-cycle pulse on any direction reversal, and frame_cnt, output, 16, frames elapsed.

Function
REQ-015 SHALL raise frame tick for exactly one cycle when sy==V_RES and sx==0 (start of vertical blank).
REQ-016 SHALL use FSM states IDLE, MOVE_X, MOVE_Y, DONE: IDLE->MOVE_X on an accepted tick; then MOVE_X->MOVE_Y->DONE->IDLE, one cycle each.
REQ-017 SHALL accept a tick only in IDLE and only if pause==0 or step==1; all other ticks SHALL be ignored.
REQ-018 SHALL in MOVE_X, with dx==1: if qx >= H_RES-Q_SIZE-Q_SPEED, clear dx and hold qx, else add Q_SPEED.
REQ-019 SHALL in MOVE_X, with dx==0: if qx < Q_SPEED, set dx and hold qx, else subtract Q_SPEED.
REQ-020 SHALL apply the REQ-018/019 rules in MOVE_Y using qy, dy and V_RES.
REQ-021 SHALL pulse bounce in DONE if dx or dy changed this update, and SHALL increment frame_cnt by 1 (mod 2^16) in DONE.
REQ-022 SHALL compute hit = (sx>=qx && sx<qx+Q_SIZE && sy>=qy && sy<qy+Q_SIZE) using CORDW+1-bit sums.
REQ-023 SHALL register paint outputs with 1-cycle latency from sx/sy/de: if de==0, 0/0/0; if hit, fg colour; else background 1/3/7.
REQ-024 SHALL keep qx/qy stable throughout the active frame; updates occur only in vertical blank.

Reset
REQ-025 SHALL on rst_pix_n low immediately set qx=Q_X0, qy=Q_Y0, dx=dy=1, state IDLE, paint outputs 0, bounce 0, frame_cnt 0, fg colour F/F/F.
REQ-026 SHALL abandon an in-progress update on reset mid-FSM; no partial position is retained.

Configuration
REQ-027 SHALL, with SQUARE_COLOR_CYCLE_EN defined, advance fg colour through the package palette (F/F/F, F/0/0, 0/F/0, 0/0/F, wrap) on each bounce pulse.
REQ-028 SHALL, without SQUARE_COLOR_CYCLE_EN, keep fg fixed at F/F/F.

Structure
REQ-029 SHALL take the FSM state enum, the background colour, and the 4-entry palette from package square_pkg.
REQ-030 SHALL place tick detection in sub-module frame_tick (inputs sx, sy; output tick).

Verification
REQ-031 Reset, then 1 frame -> qx=222, qy=142, frame_cnt=1, bounce=0.
REQ-032 Q_X0=438, dx=1, 1 frame -> dx=0, qx=438, bounce pulses 1 cycle; next frame qx=436.
REQ-033 pause=1 for 3 frames -> qx/qy/frame_cnt unchanged; step=1 on one tick -> exactly one update.
REQ-034 Pixel (220,140) with square at 220/140 and de=1 -> paint F/F/F one cycle later; (219,140) -> 1/3/7; de=0 -> 0/0/0.
REQ-035 Reset asserted in MOVE_Y -> outputs equal reset values immediately, state IDLE.
REQ-036 SQUARE_COLOR_CYCLE_EN defined, two bounces -> fg F/0/0 then 0/F/0.

Source files
------------

// File: rtl/square_pkg.sv
// Shared types for the bouncing-square animation: FSM states, colour record,
// background colour and the foreground palette lookup.
package square_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MOVE_X = 2'd1,
    MOVE_Y = 2'd2,
    DONE   = 2'd3
  } anim_state_t;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb_t;

  localparam rgb_t BG_COLOR = 12'h137;

  // Four-entry foreground palette; entry 0 is the reset colour.
  function automatic rgb_t palette_color(input logic [1:0] idx);
    rgb_t c;
    case (idx)
      2'd0:    c = 12'hFFF;
      2'd1:    c = 12'hF00;
      2'd2:    c = 12'h0F0;
      default: c = 12'h00F;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/frame_tick.sv
// Start-of-vertical-blank detector: high for the single pixel where the raster
// reaches the first blanking line at column 0.
module frame_tick #(
  parameter int CORDW = 10,
  parameter int V_RES = 480
) (
  input  logic [CORDW-1:0] sx,
  input  logic [CORDW-1:0] sy,
  output logic             tick
);

  assign tick = (sy == CORDW'(V_RES)) && (sx == '0);

endmodule

// File: rtl/square_anim_ctrl.sv
// Bouncing-square animation controller: moves the square once per frame during
// vertical blank and paints it. Optional macro SQUARE_COLOR_CYCLE_EN steps the
// foreground through the palette on every bounce.
module square_anim_ctrl
  import square_pkg::*;
#(
  parameter int CORDW   = 10,
  parameter int H_RES   = 640,
  parameter int V_RES   = 480,
  parameter int Q_SIZE  = 200,
  parameter int Q_SPEED = 2,
  parameter int Q_X0    = 220,
  parameter int Q_Y0    = 140
) (
  input  logic             clk_pix,
  input  logic             rst_pix_n,
  input  logic [CORDW-1:0] sx,
  input  logic [CORDW-1:0] sy,
  input  logic             de,
  input  logic             pause,
  input  logic             step,
  output logic [CORDW-1:0] qx,
  output logic [CORDW-1:0] qy,
  output logic [3:0]       paint_r,
  output logic [3:0]       paint_g,
  output logic [3:0]       paint_b,
  output logic             bounce,
  output logic [15:0]      frame_cnt
);

  anim_state_t      state_reg;
  anim_state_t      state_next;
  logic             tick;
  logic             accept;
  logic [CORDW-1:0] pos [2];
  logic             flip [2];
  logic [15:0]      frame_cnt_reg;
  rgb_t             fg;
  rgb_t             paint_reg;
  logic [CORDW:0]   x_end;
  logic [CORDW:0]   y_end;
  logic             hit;

  frame_tick #(
    .CORDW (CORDW),
    .V_RES (V_RES)
  ) u_frame_tick (
    .sx   (sx),
    .sy   (sy),
    .tick (tick)
  );

  assign accept = tick && (!pause || step);

  always_ff @(posedge clk_pix or negedge rst_pix_n) begin
    if (!rst_pix_n) state_reg <= IDLE;
    else            state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept) state_next = MOVE_X;
      MOVE_X:  state_next = MOVE_Y;
      MOVE_Y:  state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    bounce = 1'b0;
    if (state_reg == DONE) bounce = flip[0] | flip[1];
  end

  // Axis 0 is horizontal (qx/dx), axis 1 vertical (qy/dy); each updates in its own state.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_axis
      localparam int          LIMIT     = (gi == 0) ? H_RES - Q_SIZE - Q_SPEED
                                                    : V_RES - Q_SIZE - Q_SPEED;
      localparam int          POS0      = (gi == 0) ? Q_X0 : Q_Y0;
      localparam anim_state_t ACTIVE_ST = (gi == 0) ? MOVE_X : MOVE_Y;

      logic [CORDW-1:0] pos_reg;
      logic             dir_reg;
      logic             flip_reg;

      always_ff @(posedge clk_pix or negedge rst_pix_n) begin
        if (!rst_pix_n) begin
          pos_reg  <= CORDW'(POS0);
          dir_reg  <= 1'b1;
          flip_reg <= 1'b0;
        end else if (state_reg == IDLE) begin
          flip_reg <= 1'b0;
        end else if (state_reg == ACTIVE_ST) begin
          if (dir_reg) begin
            if (pos_reg >= CORDW'(LIMIT)) begin
              dir_reg  <= 1'b0;
              flip_reg <= 1'b1;
            end else begin
              pos_reg <= pos_reg + CORDW'(Q_SPEED);
            end
          end else begin
            if (pos_reg < CORDW'(Q_SPEED)) begin
              dir_reg  <= 1'b1;
              flip_reg <= 1'b1;
            end else begin
              pos_reg <= pos_reg - CORDW'(Q_SPEED);
            end
          end
        end
      end

      assign pos[gi]  = pos_reg;
      assign flip[gi] = flip_reg;
    end
  endgenerate

  assign qx = pos[0];
  assign qy = pos[1];

  always_ff @(posedge clk_pix or negedge rst_pix_n) begin
    if (!rst_pix_n)              frame_cnt_reg <= '0;
    else if (state_reg == DONE)  frame_cnt_reg <= frame_cnt_reg + 16'd1;
  end

  assign frame_cnt = frame_cnt_reg;

`ifdef SQUARE_COLOR_CYCLE_EN
  logic [1:0] fg_idx_reg;

  always_ff @(posedge clk_pix or negedge rst_pix_n) begin
    if (!rst_pix_n)  fg_idx_reg <= 2'd0;
    else if (bounce) fg_idx_reg <= fg_idx_reg + 2'd1;
  end

  assign fg = palette_color(fg_idx_reg);
`else
  assign fg = palette_color(2'd0);
`endif

  // One extra bit on the far edge so a square touching the screen limit cannot wrap.
  assign x_end = {1'b0, qx} + (CORDW+1)'(Q_SIZE);
  assign y_end = {1'b0, qy} + (CORDW+1)'(Q_SIZE);
  assign hit   = (sx >= qx) && ({1'b0, sx} < x_end) &&
                 (sy >= qy) && ({1'b0, sy} < y_end);

  always_ff @(posedge clk_pix or negedge rst_pix_n) begin
    if (!rst_pix_n)  paint_reg <= '0;
    else if (!de)    paint_reg <= '0;
    else if (hit)    paint_reg <= fg;
    else             paint_reg <= BG_COLOR;
  end

  assign paint_r = paint_reg.r;
  assign paint_g = paint_reg.g;
  assign paint_b = paint_reg.b;

endmodule

// File: tb/tb_square_anim_ctrl.sv
// Directed bench for square_anim_ctrl: a default instance and one started at the
// right-hand bounce point, driven with synthetic frame ticks and pixel probes.
module tb_square_anim_ctrl;
  import square_pkg::*;

  localparam int CORDW = 10;
  localparam int V_RES = 480;

  logic             clk_pix = 1'b0;
  logic             rst_pix_n;
  logic [CORDW-1:0] sx, sy;
  logic             de, pause, step;

  logic [CORDW-1:0] qx_a, qy_a, qx_b, qy_b;
  logic [3:0]       r_a, g_a, b_a, r_b, g_b, b_b;
  logic             bounce_a, bounce_b;
  logic [15:0]      fc_a, fc_b;

  int checks = 0;
  int errors = 0;

  always #5 clk_pix = ~clk_pix;

  square_anim_ctrl dut (
    .clk_pix(clk_pix), .rst_pix_n(rst_pix_n), .sx(sx), .sy(sy), .de(de),
    .pause(pause), .step(step), .qx(qx_a), .qy(qy_a),
    .paint_r(r_a), .paint_g(g_a), .paint_b(b_a),
    .bounce(bounce_a), .frame_cnt(fc_a)
  );

  square_anim_ctrl #(.Q_X0(438)) dut_b (
    .clk_pix(clk_pix), .rst_pix_n(rst_pix_n), .sx(sx), .sy(sy), .de(de),
    .pause(pause), .step(step), .qx(qx_b), .qy(qy_b),
    .paint_r(r_b), .paint_g(g_b), .paint_b(b_b),
    .bounce(bounce_b), .frame_cnt(fc_b)
  );

  typedef struct {
    string      name;
    logic [9:0] px;
    logic [9:0] py;
    logic       pde;
    logic [11:0] exp_rgb;
  } pix_vec_t;

  pix_vec_t vecs [8];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // One synthetic frame: tick pixel, then enough cycles for the full update.
  task automatic run_frame(output int nb_a, output int nb_b);
    nb_a = 0;
    nb_b = 0;
    de = 1'b0;
    sx = '0;
    sy = 10'(V_RES);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk_pix); #1;
      if (c == 0) sx = 10'd1;
      nb_a += int'(bounce_a);
      nb_b += int'(bounce_b);
    end
    sx = '0;
    sy = '0;
    $display("frame: A qx=%0d qy=%0d fc=%0d bnc=%0d | B qx=%0d qy=%0d bnc=%0d",
             qx_a, qy_a, fc_a, nb_a, qx_b, qy_b, nb_b);
  endtask

  task automatic probe(input logic [9:0] px, input logic [9:0] py, input logic pde);
    sx = px;
    sy = py;
    de = pde;
    @(posedge clk_pix); #1;
    de = 1'b0;
  endtask

  int na, nb, nframes, nbounce;
  logic [11:0] exp_fg1, exp_fg2;

  initial begin
    vecs[0] = '{"pix_inside_corner", 10'd220, 10'd140, 1'b1, 12'hFFF};
    vecs[1] = '{"pix_left_of_sq",    10'd219, 10'd140, 1'b1, 12'h137};
    vecs[2] = '{"pix_de_low",        10'd220, 10'd140, 1'b0, 12'h000};
    vecs[3] = '{"pix_last_inside",   10'd419, 10'd339, 1'b1, 12'hFFF};
    vecs[4] = '{"pix_right_edge",    10'd420, 10'd140, 1'b1, 12'h137};
    vecs[5] = '{"pix_below_edge",    10'd220, 10'd340, 1'b1, 12'h137};
    vecs[6] = '{"pix_above_edge",    10'd220, 10'd139, 1'b1, 12'h137};
    vecs[7] = '{"pix_origin",        10'd0,   10'd0,   1'b1, 12'h137};

`ifdef SQUARE_COLOR_CYCLE_EN
    exp_fg1 = 12'hF00;
    exp_fg2 = 12'h0F0;
`else
    exp_fg1 = 12'hFFF;
    exp_fg2 = 12'hFFF;
`endif

    rst_pix_n = 1'b0;
    sx = '0; sy = '0; de = 1'b0; pause = 1'b0; step = 1'b0;
    repeat (3) @(posedge clk_pix);
    #1;
    check("rst_qx", int'(qx_a), 220);
    check("rst_qy", int'(qy_a), 140);
    check("rst_fc", int'(fc_a), 0);
    check("rst_bounce", int'(bounce_a), 0);
    check("rst_paint", int'({r_a, g_a, b_a}), 0);
    check("rst_qx_b", int'(qx_b), 438);
    rst_pix_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      probe(vecs[i].px, vecs[i].py, vecs[i].pde);
      $display("pixel %s (%0d,%0d,de=%0b) -> %03h", vecs[i].name,
               vecs[i].px, vecs[i].py, vecs[i].pde, {r_a, g_a, b_a});
      check(vecs[i].name, int'({r_a, g_a, b_a}), int'(vecs[i].exp_rgb));
    end

    run_frame(na, nb);
    check("f1_qx", int'(qx_a), 222);
    check("f1_qy", int'(qy_a), 142);
    check("f1_fc", int'(fc_a), 1);
    check("f1_bounce_cnt", na, 0);
    check("f1_b_qx_hold", int'(qx_b), 438);
    check("f1_b_bounce_cnt", nb, 1);

    run_frame(na, nb);
    check("f2_b_qx", int'(qx_b), 436);
    check("f2_b_bounce_cnt", nb, 0);
    check("f2_qx", int'(qx_a), 224);
    check("f2_fc", int'(fc_a), 2);

    pause = 1'b1;
    for (int f = 0; f < 3; f++) run_frame(na, nb);
    check("pause_qx", int'(qx_a), 224);
    check("pause_qy", int'(qy_a), 144);
    check("pause_fc", int'(fc_a), 2);

    step = 1'b1;
    run_frame(na, nb);
    step = 1'b0;
    check("step_qx", int'(qx_a), 226);
    check("step_qy", int'(qy_a), 146);
    check("step_fc", int'(fc_a), 3);
    run_frame(na, nb);
    check("after_step_qx", int'(qx_a), 226);
    check("after_step_fc", int'(fc_a), 3);
    pause = 1'b0;

    probe(10'd434, 10'd146, 1'b1);
    check("fg_after_bounce1", int'({r_b, g_b, b_b}), int'(exp_fg1));
    check("a_bg_at_434", int'({r_a, g_a, b_a}), 12'h137);

    // Drive dut_b down until its bottom bounce; expected on the 67th frame.
    nframes = 0;
    nbounce = 0;
    while (nbounce == 0 && nframes < 100) begin
      run_frame(na, nb);
      nbounce = nb;
      nframes++;
    end
    check("ybounce_frames", nframes, 67);
    check("ybounce_qy_b", int'(qy_b), 278);
    check("ybounce_qx_b", int'(qx_b), 300);
    probe(10'd300, 10'd278, 1'b1);
    check("fg_after_bounce2", int'({r_b, g_b, b_b}), int'(exp_fg2));

    // Reset while dut is in MOVE_Y.
    sx = '0;
    sy = 10'(V_RES);
    @(posedge clk_pix); #1;
    sx = 10'd1;
    @(posedge clk_pix); #1;
    check("pre_rst_state", int'(dut.state_reg), int'(MOVE_Y));
    rst_pix_n = 1'b0;
    #1;
    check("midrst_state", int'(dut.state_reg), int'(IDLE));
    check("midrst_qx", int'(qx_a), 220);
    check("midrst_qy", int'(qy_a), 140);
    check("midrst_fc", int'(fc_a), 0);
    check("midrst_bounce", int'(bounce_a), 0);
    check("midrst_qx_b", int'(qx_b), 438);
    @(posedge clk_pix); #1;
    rst_pix_n = 1'b1;
    run_frame(na, nb);
    check("post_rst_qx", int'(qx_a), 222);
    check("post_rst_fc", int'(fc_a), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
